seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Sequential unsigned restoring divider; the division counterpart of the team's shift-add Booth multiplier datapath.
- Resolves one quotient bit per cycle, MSB first.
- Uses an internal iteration down-counter preloaded with WIDTH, in the same style as the multiplier's bit counter.
- Sits beside the multiplier in the arithmetic unit and is driven by the same start/done control handshake.

Parameters:
- WIDTH, 16, operand, quotient and remainder width in bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge
- divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge
- busy  output  1  high while state is ITER
- done  output  1  one-cycle pulse; results are valid in that cycle
- quotient  output  WIDTH  result quotient; holds until the next accepted start
- remainder  output  WIDTH  result remainder; holds until the next accepted start
- div_by_zero  output  1  set with done when the captured divisor was 0; holds until the next accepted start

Behaviour:
- Reset: on a clk edge with rst=1, state becomes IDLE and every output and internal register (A, Q, M, cnt) is cleared to 0.
- rst overrides every other input, including mid-ITER; an aborted operation produces no done.
- States and transitions:
  - IDLE: on start=1, capture M=divisor, Q=dividend, A=0, cnt=WIDTH. Clear div_by_zero.
    - If divisor==0, go to DONE.
    - Otherwise go to ITER.
  - ITER: each edge performs one step:
    - {A,Q} shifts left by 1.
    - T = {1'b0,A_shifted} - {1'b0,M}, computed in WIDTH+1 bits.
    - If T[WIDTH]=1 (negative): A keeps A_shifted and Q[0]=0.
    - Otherwise: A=T[WIDTH-1:0] and Q[0]=1.
    - cnt decrements by 1.
    - On the edge where cnt==1 (last step), go to DONE.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE.
- Output latching:
  - Normal path: quotient=Q and remainder=A are registered on the last ITER edge, so they are valid in the same cycle done=1.
  - Divide-by-zero path: quotient is all-ones, remainder=dividend, div_by_zero=1, done=1 in the cycle after the start edge.
- Latency:
  - Normal path: done is high in cycle WIDTH+1 after the start-accept edge (17 for WIDTH=16).
  - Divide-by-zero path: done is high in cycle 1.
- busy is 1 exactly during the WIDTH ITER cycles and 0 in IDLE and DONE.
- start is ignored in ITER and DONE. No queuing; the requester must retry in IDLE.
- Operand inputs are don't-care except on the accepted start edge. Changing them mid-operation has no effect.
- Arithmetic: fully unsigned. Invariant at done (when div_by_zero=0): dividend == quotient*divisor + remainder, with remainder < divisor.
- cnt never wraps: its decrement is gated to ITER only.

Test Plan:
- rst=1 for 2 cycles, then idle -> busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- start with 100/7 -> busy high 16 cycles; done pulse in cycle 17 with quotient=14, remainder=2, div_by_zero=0; outputs held afterwards.
- Boundary operands:
  - 0xFFFF/1 -> quotient=0xFFFF, remainder=0.
  - 3/10 -> quotient=0, remainder=3.
  - 0xFFFF/0xFFFF -> quotient=1, remainder=0.
- start with 5/0 -> done in cycle 1, quotient=0xFFFF, remainder=5, div_by_zero=1, busy never high.
- start 1000/33, then pulse start with 9/3 at cycle 5 -> second request ignored; done in cycle 17 with quotient=30, remainder=10.
- start 1000/33, assert rst at cycle 8 -> next edge gives IDLE with all outputs 0 and no done; a fresh start 50/5 then gives quotient=10, remainder=0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider.
// Resolves one quotient bit per clock, MSB first, using the A/Q/M register
// arrangement of the shift-add multiplier and the same start/done handshake.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   trial;

  // One restoring step: shift {A,Q} left, trial-subtract M, keep or restore.
  always_comb begin
    a_shift = {a[WIDTH-2:0], q[WIDTH-1]};
    q_shift = {q[WIDTH-2:0], 1'b0};
    trial   = {1'b0, a_shift} - {1'b0, m};
    if (trial[WIDTH]) begin
      a_next = a_shift;
      q_next = q_shift;
    end else begin
      a_next = trial[WIDTH-1:0];
      q_next = {q_shift[WIDTH-1:1], 1'b1};
    end
  end

  assign busy = (state == S_ITER);
  assign done = (state == S_DONE);

  // Control FSM and datapath registers; results are latched on the final step
  // so they are already valid during the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m           <= divisor;
            q           <= dividend;
            a           <= '0;
            cnt         <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            quotient  <= q_next;
            remainder <= a_next;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider.
// The driver pushes the expected result of every accepted request into a
// queue; an independent monitor pops and compares whenever done is seen.
module tb_seq_divider;

  localparam int WIDTH = 16;

  typedef struct {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
    int               startCyc;
    int               lat;
    int               busyCycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  exp_t sb[$];
  exp_t lastExp;
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   busyCnt  = 0;

  seq_divider #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer division, divide-by-zero convention.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int unsigned ai = a;
    int unsigned bi = b;
    if (bi == 0) begin
      e.quo = '1; e.rem = a; e.dz = 1'b1; e.lat = 1; e.busyCycles = 0;
    end else begin
      e.quo = WIDTH'(ai / bi); e.rem = WIDTH'(ai % bi); e.dz = 1'b0;
      e.lat = WIDTH + 1; e.busyCycles = WIDTH;
    end
    e.startCyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request in IDLE and push its expected result; operands are
  // scrambled right after the accept edge to show they are not re-read.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e = model(a, b);
    e.startCyc = cyc;
    sb.push_back(e);
    lastExp = e;
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Start pulse that the DUT must ignore (issued while not IDLE).
  task automatic pulseStart(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout actual=0 required=1 after %0d cycles", limit);
    end
  endtask

  task automatic checkHold();
    repeat (3) @(negedge clk);
    checkOutput("hold_quotient", quotient, lastExp.quo);
    checkOutput("hold_remainder", remainder, lastExp.rem);
    checkOutput("hold_dz", div_by_zero, lastExp.dz);
    checkOutput("hold_done_low", done, 0);
  endtask

  // Monitor: counts busy cycles and checks every done pulse against the queue.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.quo);
        checkOutput("remainder", remainder, e.rem);
        checkOutput("div_by_zero", div_by_zero, e.dz);
        checkOutput("latency", cyc - e.startCyc, e.lat);
        checkOutput("busy_cycles", busyCnt, e.busyCycles);
        checkOutput("busy_in_done", busy, 0);
      end
      busyCnt = 0;
    end else if (busy) begin
      busyCnt++;
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dz", div_by_zero, 0);

    // Basic operation and result hold.
    applyStimulus(16'd100, 16'd7);
    waitDone(40);
    checkHold();

    // Boundary operands.
    applyStimulus(16'hFFFF, 16'd1);
    waitDone(40);
    applyStimulus(16'd3, 16'd10);
    waitDone(40);
    applyStimulus(16'hFFFF, 16'hFFFF);
    waitDone(40);

    // Divide by zero.
    applyStimulus(16'd5, 16'd0);
    waitDone(40);
    checkHold();

    // Start while busy is ignored.
    applyStimulus(16'd1000, 16'd33);
    repeat (4) @(negedge clk);
    pulseStart(16'd9, 16'd3);
    waitDone(40);
    checkHold();

    // Reset mid-operation aborts without a done pulse.
    applyStimulus(16'd1000, 16'd33);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    busyCnt = 0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_dz", div_by_zero, 0);
    repeat (20) @(negedge clk);
    applyStimulus(16'd50, 16'd5);
    waitDone(40);

    // Randomized operands, including small and zero divisors.
    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int mode;
      a    = WIDTH'($urandom);
      mode = $urandom_range(0, 7);
      if (mode == 0)      b = '0;
      else if (mode < 4)  b = WIDTH'($urandom_range(1, 15));
      else                b = WIDTH'($urandom);
      if (mode == 7) a = WIDTH'($urandom_range(0, 20));
      applyStimulus(a, b);
      waitDone(40);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
